// File: rtl/block_word_loader.sv
// block_word_loader
//   Assembles 32-bit work words into 512-bit SHA-256 message blocks. The assembly
//   buffer and the output register form a ping-pong pair, so the next block can
//   fill while the hashing core still holds the current one.
//
//   Optional feature macro: BLOCK_LOADER_BYTE_SWAP_EN
//     defined   - each word is byte-reversed on capture (in_word[7:0] -> slot[31:24])
//     undefined - words are stored verbatim
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_word    in   [31:0] work word
//   in_valid   in   in_word valid
//   in_last    in   final word of frame (qualified by in_valid)
//   in_ready   out  loader accepts a word this cycle
//   abort      in   synchronous flush of all block state
//   out_block  out  [511:0] assembled block, word k at [32k+31:32k]
//   out_valid  out  out_block holds an unconsumed block
//   out_ready  in   hashing core accepts out_block
//   word_cnt   out  [3:0] next word slot
//   blk_cnt    out  [15:0] blocks delivered, wrapping
//   frame_err  out  one-cycle pulse on a malformed frame
module block_word_loader (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  in_word,
   input  logic         in_valid,
   input  logic         in_last,
   output logic         in_ready,
   input  logic         abort,
   output logic [511:0] out_block,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [3:0]   word_cnt,
   output logic [15:0]  blk_cnt,
   output logic         frame_err
);

   localparam int unsigned Words = 16;
   localparam int unsigned WordW = 32;

   typedef enum logic [0:0] {StFill, StFull} state_e;

   state_e                           state_q;
   logic                             run_q;  // low only until the first edge after reset
   logic [3:0]                       cnt_q;
   logic [15:0]                      blk_cnt_q;
   logic                             out_valid_q;
   logic [511:0]                     out_block_q;
   logic                             frame_err_q;
   logic [Words-1:0][WordW-1:0]      asm_q;

   logic                             in_hs;
   logic                             out_hs;
   logic [WordW-1:0]                 cap_word;

   // in_ready depends on registered state only
   assign in_ready = run_q && (state_q == StFill);
   assign in_hs    = in_valid && in_ready;
   assign out_hs   = out_valid_q && out_ready;

`ifdef BLOCK_LOADER_BYTE_SWAP_EN
   assign cap_word = {in_word[7:0], in_word[15:8], in_word[23:16], in_word[31:24]};
`else
   assign cap_word = in_word;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StFill;
         run_q       <= 1'b0;
         cnt_q       <= '0;
         blk_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_block_q <= '0;
         frame_err_q <= 1'b0;
         asm_q       <= '0;
      end else begin
         run_q       <= 1'b1;
         frame_err_q <= 1'b0;
         if (abort) begin
            // Handshakes in this cycle are dropped; blk_cnt is kept.
            state_q     <= StFill;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
         end else begin
            if (out_hs) begin
               blk_cnt_q   <= blk_cnt_q + 16'd1;
               out_valid_q <= 1'b0;
            end
            unique case (state_q)
               StFill: begin
                  if (in_hs) begin
                     if (in_last && (cnt_q != 4'd15)) begin
                        cnt_q       <= '0;
                        frame_err_q <= 1'b1;
                     end else if (cnt_q == 4'd15) begin
                        cnt_q <= '0;
                        if (!out_valid_q || out_ready) begin
                           // Output register free (or draining now): load directly.
                           out_block_q <= {cap_word, asm_q[Words-2:0]};
                           out_valid_q <= 1'b1;
                        end else begin
                           asm_q[cnt_q] <= cap_word;
                           state_q      <= StFull;
                        end
                     end else begin
                        asm_q[cnt_q] <= cap_word;
                        cnt_q        <= cnt_q + 4'd1;
                     end
                  end
               end
               StFull: begin
                  if (out_hs) begin
                     out_block_q <= asm_q;
                     out_valid_q <= 1'b1;
                     state_q     <= StFill;
                  end
               end
               default: state_q <= StFill;
            endcase
         end
      end
   end

   assign out_block = out_block_q;
   assign out_valid = out_valid_q;
   assign word_cnt  = cnt_q;
   assign blk_cnt   = blk_cnt_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_block_word_loader.sv
module tb_block_word_loader;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  in_word;
   logic         in_valid;
   logic         in_last;
   logic         in_ready;
   logic         abort;
   logic [511:0] out_block;
   logic         out_valid;
   logic         out_ready;
   logic [3:0]   word_cnt;
   logic [15:0]  blk_cnt;
   logic         frame_err;

   block_word_loader dut (
      .clk       (clk),
      .rst       (rst),
      .in_word   (in_word),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .abort     (abort),
      .out_block (out_block),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .word_cnt  (word_cnt),
      .blk_cnt   (blk_cnt),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int stalls   = 0;
   int fe_seen  = 0;

   logic [511:0] sb_q[$];       // expected blocks, in delivery order
   logic [31:0]  mw [16];       // model of the assembly slots
   int           mcnt = 0;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] stored(input logic [31:0] w);
`ifdef BLOCK_LOADER_BYTE_SWAP_EN
      return {<<8{w}};
`else
      return w;
`endif
   endfunction

   // Drive one word; returns #1 after the edge on which it was accepted.
   task automatic send_word(input logic [31:0] w, input logic last);
      int t = 0;
      logic [511:0] blk;
      in_word  = w;
      in_valid = 1'b1;
      in_last  = last;
      while (!in_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) begin
         chk("in_ready_wait", {511'd0, in_ready}, 512'd1);
         in_valid = 1'b0;
         return;
      end
      stalls += t;
      if (last && mcnt != 15) begin
         mcnt = 0;
      end else if (mcnt == 15) begin
         for (int k = 0; k < 15; k++) blk[32*k +: 32] = mw[k];
         blk[511:480] = stored(w);
         sb_q.push_back(blk);
         mcnt = 0;
      end else begin
         mw[mcnt] = stored(w);
         mcnt++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_block(input logic [31:0] base);
      for (int k = 0; k < 16; k++) send_word(base + 32'(k), k == 15);
   endtask

   // Output side: the handshake completes at the next rising edge.
   always @(negedge clk) begin
      if (frame_err) fe_seen++;
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) chk("unexpected_block", out_block, '0);
         else chk("block", out_block, sb_q.pop_front());
      end
   end

   logic [511:0] held;
   logic [31:0]  exp_lo, exp_hi;

   initial begin
      rst = 1'b1; in_word = '0; in_valid = 1'b0; in_last = 1'b0;
      abort = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {511'd0, in_ready}, 512'd0);
      chk("rst_out_valid", {511'd0, out_valid}, 512'd0);
      chk("rst_word_cnt", {508'd0, word_cnt}, 512'd0);
      chk("rst_blk_cnt", {496'd0, blk_cnt}, 512'd0);
      chk("rst_out_block", out_block, 512'd0);
      chk("rst_frame_err", {511'd0, frame_err}, 512'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rel_in_ready", {511'd0, in_ready}, 512'd1);

      // Single block, consumer ready
      out_ready = 1'b1;
      send_block(32'h1122_3300);
`ifdef BLOCK_LOADER_BYTE_SWAP_EN
      exp_lo = 32'h0033_2211; exp_hi = 32'h0F33_2211;
`else
      exp_lo = 32'h1122_3300; exp_hi = 32'h1122_330F;
`endif
      chk("lat_out_valid", {511'd0, out_valid}, 512'd1);
      chk("blk_word0", {480'd0, out_block[31:0]}, {480'd0, exp_lo});
      chk("blk_word15", {480'd0, out_block[511:480]}, {480'd0, exp_hi});
      @(posedge clk); #1;
      chk("blk_cnt_1", {496'd0, blk_cnt}, 512'd1);
      chk("drain_out_valid", {511'd0, out_valid}, 512'd0);

      // Throughput: two back-to-back blocks without bubbles
      stalls = 0;
      send_block(32'hA000_0000);
      send_block(32'hB000_0000);
      chk("stalls", 512'(stalls), 512'd0);
      @(posedge clk); #1;
      chk("blk_cnt_3", {496'd0, blk_cnt}, 512'd3);

      // Backpressure: second block waits in the assembly buffer
      out_ready = 1'b0;
      send_block(32'hC000_0000);
      held = sb_q[0];
      send_block(32'hD000_0000);
      chk("full_in_ready", {511'd0, in_ready}, 512'd0);
      chk("full_out_valid", {511'd0, out_valid}, 512'd1);
      chk("full_word_cnt", {508'd0, word_cnt}, 512'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("held_block", out_block, held);
      chk("held_blk_cnt", {496'd0, blk_cnt}, 512'd3);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_out_valid", {511'd0, out_valid}, 512'd1);
      chk("bp_second", out_block, sb_q[0]);
      chk("bp_blk_cnt", {496'd0, blk_cnt}, 512'd4);
      chk("bp_in_ready", {511'd0, in_ready}, 512'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_blk_cnt2", {496'd0, blk_cnt}, 512'd5);

      // Early in_last at slot 5
      for (int k = 0; k < 5; k++) send_word(32'hEE00_0000 + 32'(k), 1'b0);
      send_word(32'hEE00_0005, 1'b1);
      chk("fe_pulse", {511'd0, frame_err}, 512'd1);
      chk("fe_word_cnt", {508'd0, word_cnt}, 512'd0);
      @(posedge clk); #1;
      chk("fe_one_cycle", {511'd0, frame_err}, 512'd0);
      send_block(32'h5500_0000);
      @(posedge clk); #1;
      chk("fe_blk_cnt", {496'd0, blk_cnt}, 512'd6);

      // Abort with a pending output block and a partial frame
      out_ready = 1'b0;
      send_block(32'h7700_0000);
      for (int k = 0; k < 9; k++) send_word(32'h8800_0000 + 32'(k), 1'b0);
      chk("ab_word_cnt9", {508'd0, word_cnt}, 512'd9);
      in_word = 32'hDEAD_BEEF; in_valid = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; in_valid = 1'b0;
      sb_q.delete();
      mcnt = 0;
      chk("ab_word_cnt", {508'd0, word_cnt}, 512'd0);
      chk("ab_out_valid", {511'd0, out_valid}, 512'd0);
      chk("ab_frame_err", {511'd0, frame_err}, 512'd0);
      chk("ab_blk_cnt", {496'd0, blk_cnt}, 512'd6);
      out_ready = 1'b1;
      send_block(32'h9900_0000);
      @(posedge clk); #1;
      chk("ab_blk_cnt2", {496'd0, blk_cnt}, 512'd7);
      chk("sb_empty", 512'(sb_q.size()), 512'd0);
      chk("fe_total", 512'(fe_seen), 512'd1);

      // Asynchronous reset while FULL
      out_ready = 1'b0;
      send_block(32'h1000_0000);
      send_block(32'h2000_0000);
      #2 rst = 1'b1;
      #1;
      chk("ar_out_valid", {511'd0, out_valid}, 512'd0);
      chk("ar_word_cnt", {508'd0, word_cnt}, 512'd0);
      chk("ar_blk_cnt", {496'd0, blk_cnt}, 512'd0);
      chk("ar_out_block", out_block, 512'd0);
      chk("ar_in_ready", {511'd0, in_ready}, 512'd0);
      sb_q.delete();
      mcnt = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("ar_rel_in_ready", {511'd0, in_ready}, 512'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
